// File: rtl/flood_fill_opener_pkg.sv
// Shared definitions for the flood-fill open engine.
// Holds the engine state encoding, the board_cover state encodings, and the
// special board values. It also holds the neighbour offset table used by the
// expansion walk.
package flood_fill_opener_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_READ  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_OPEN  = 3'd4,
        ST_NEIGH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] COVER_COVERED = 2'b00;
    localparam logic [1:0] COVER_FLAGGED = 2'b01;
    localparam logic [1:0] COVER_OPENED  = 2'b10;

    localparam logic [4:0] MINE_VAL = 5'd9;
    localparam logic [4:0] ZERO_VAL = 5'd0;

    localparam logic [2:0] LAST_NEIGH = 3'd7;

    // Neighbour walk order: NW, N, NE, W, E, SW, S, SE (y grows southwards).
    function automatic logic signed [1:0] neigh_dx(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3, 3'd5: neigh_dx = -2'sd1;
            3'd1, 3'd6:       neigh_dx = 2'sd0;
            default:          neigh_dx = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] neigh_dy(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: neigh_dy = -2'sd1;
            3'd3, 3'd4:       neigh_dy = 2'sd0;
            default:          neigh_dy = 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/flood_fill_opener_coord_fifo.sv
// coord_fifo: synchronous FIFO holding packed cell coordinates for the
// breadth-first walk.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         synchronous clear; a push in the same cycle becomes the
//                   only entry
//   i_push, i_din   write one entry
//   i_pop           drop the head entry (ignored when empty)
//   o_head          current head entry
//   o_empty         no entries stored
module coord_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_wr_next;
    logic [AW-1:0]    w_rd_next;
    logic             w_pop_ok;

    // A clear rewinds the write pointer first so a simultaneous push lands in slot 0.
    assign w_wr_addr = i_clear ? '0 : r_wr_ptr;
    assign w_wr_next = (w_wr_addr == AW'(DEPTH - 1)) ? '0 : w_wr_addr + AW'(1);
    assign w_rd_next = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
    assign w_pop_ok  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? w_wr_next : '0;
            r_count  <= i_push ? CW'(1) : '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + CW'(i_push) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wr_addr] <= i_din;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/flood_fill_opener.sv
// flood_fill_opener: sequential open engine. It takes a seed cell and opens
// it. Zero cells expand breadth-first into their connected zero region and
// the numbered border around it.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   start, start_x/y        one-cycle request with the seed cell (IDLE only)
//   rd_x/rd_y               read address for board and board_cover
//   cell_val, cover_val     read data, one cycle after the address
//   open, open_x/y          single-cell open pulse to board_cover
//   busy, done              activity flag and completion pulse
//   hit_mine, cells_opened  result of the last accepted request
module flood_fill_opener
    import flood_fill_opener_pkg::*;
#(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [X_COORD_BITS-1:0]              start_x,
    input  logic [Y_COORD_BITS-1:0]              start_y,
    output logic [X_COORD_BITS-1:0]              rd_x,
    output logic [Y_COORD_BITS-1:0]              rd_y,
    input  logic [4:0]                           cell_val,
    input  logic [1:0]                           cover_val,
    output logic                                 open,
    output logic [X_COORD_BITS-1:0]              open_x,
    output logic [Y_COORD_BITS-1:0]              open_y,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 hit_mine,
    output logic [X_COORD_BITS+Y_COORD_BITS:0]   cells_opened
);

    localparam int XB    = X_COORD_BITS;
    localparam int YB    = Y_COORD_BITS;
    localparam int IDX_W = XB + YB;
    localparam int CNT_W = IDX_W + 1;
    localparam int CELLS = X_SIZE * Y_SIZE;
    localparam logic signed [XB:0] X_MAX = (XB + 1)'(X_SIZE - 1);
    localparam logic signed [YB:0] Y_MAX = (YB + 1)'(Y_SIZE - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [XB-1:0]      r_cur_x;
    logic [YB-1:0]      r_cur_y;
    logic [2:0]         r_nidx;
    logic [CELLS-1:0]   r_pending;
    logic               r_hit_mine;
    logic [CNT_W-1:0]   r_cells_opened;

    logic               w_fifo_clear;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_fifo_empty;
    logic [IDX_W-1:0]   w_fifo_din;
    logic [IDX_W-1:0]   w_fifo_head;

    logic signed [1:0]  w_dx;
    logic signed [1:0]  w_dy;
    logic signed [XB:0] w_nx;
    logic signed [YB:0] w_ny;
    logic [XB-1:0]      w_nx_u;
    logic [YB-1:0]      w_ny_u;
    logic               w_in_bounds;
    logic               w_nbr_new;
    logic [IDX_W-1:0]   w_nbr_idx;
    logic [IDX_W-1:0]   w_seed_idx;
    logic               w_open;

    function automatic logic [IDX_W-1:0] cell_index(input logic [XB-1:0] x,
                                                    input logic [YB-1:0] y);
        return IDX_W'(y) * IDX_W'(X_SIZE) + IDX_W'(x);
    endfunction

    coord_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (CELLS)
    ) u_queue (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clear (w_fifo_clear),
        .i_push  (w_fifo_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_empty (w_fifo_empty)
    );

    // Neighbour coordinates carry one extra sign bit, so stepping off column 0
    // reads as negative instead of wrapping to the far edge.
    assign w_dx        = neigh_dx(r_nidx);
    assign w_dy        = neigh_dy(r_nidx);
    assign w_nx        = $signed({1'b0, r_cur_x}) + $signed({{(XB - 1){w_dx[1]}}, w_dx});
    assign w_ny        = $signed({1'b0, r_cur_y}) + $signed({{(YB - 1){w_dy[1]}}, w_dy});
    assign w_nx_u      = w_nx[XB-1:0];
    assign w_ny_u      = w_ny[YB-1:0];
    assign w_in_bounds = !w_nx[XB] && (w_nx <= X_MAX) && !w_ny[YB] && (w_ny <= Y_MAX);
    assign w_nbr_idx   = cell_index(w_nx_u, w_ny_u);
    assign w_nbr_new   = w_in_bounds && !r_pending[w_nbr_idx];
    assign w_seed_idx  = cell_index(start_x, start_y);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fifo_clear = 1'b0;
        w_fifo_push  = 1'b0;
        w_fifo_pop   = 1'b0;
        w_fifo_din   = {start_y, start_x};
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_fifo_clear = 1'b1;
                    w_fifo_push  = 1'b1;
                    w_next_state = ST_POP;
                end
            end
            ST_POP: begin
                if (w_fifo_empty) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_fifo_pop   = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ:  w_next_state = ST_EVAL;
            ST_EVAL:  w_next_state = (cover_val != COVER_COVERED) ? ST_POP : ST_OPEN;
            ST_OPEN:  w_next_state = (cell_val == ZERO_VAL) ? ST_NEIGH : ST_POP;
            ST_NEIGH: begin
                if (w_nbr_new) begin
                    w_fifo_push = 1'b1;
                    w_fifo_din  = {w_ny_u, w_nx_u};
                end
                if (r_nidx == LAST_NEIGH) begin
                    w_next_state = ST_POP;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // The pending bitmap guarantees each cell is queued at most once per request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_x        <= '0;
            r_cur_y        <= '0;
            r_nidx         <= '0;
            r_pending      <= '0;
            r_hit_mine     <= 1'b0;
            r_cells_opened <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pending             <= '0;
                        r_pending[w_seed_idx] <= 1'b1;
                        r_hit_mine            <= 1'b0;
                        r_cells_opened        <= '0;
                    end
                end
                ST_POP: begin
                    if (!w_fifo_empty) begin
                        r_cur_x <= w_fifo_head[XB-1:0];
                        r_cur_y <= w_fifo_head[IDX_W-1:XB];
                        r_nidx  <= '0;
                    end
                end
                ST_OPEN: begin
                    r_cells_opened <= r_cells_opened + CNT_W'(1);
                    if (cell_val == MINE_VAL) begin
                        r_hit_mine <= 1'b1;
                    end
                end
                ST_NEIGH: begin
                    if (w_nbr_new) begin
                        r_pending[w_nbr_idx] <= 1'b1;
                    end
                    r_nidx <= r_nidx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign w_open       = (r_state == ST_OPEN);
    assign open         = w_open;
    assign open_x       = w_open ? r_cur_x : '0;
    assign open_y       = w_open ? r_cur_y : '0;
    assign rd_x         = r_cur_x;
    assign rd_y         = r_cur_y;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign hit_mine     = r_hit_mine;
    assign cells_opened = r_cells_opened;

endmodule
